// File: rtl/bldc_deadtime_gate.sv
// Dead-time insertion and shoot-through protection for three BLDC half-bridges.
// Optional minimum on-time stretching is enabled by defining BLDC_DT_MIN_ON_EN.
module bldc_deadtime_gate #(
  parameter int DT_CYCLES     = 8,
  parameter int CNT_W         = 8,
  parameter int MIN_ON_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic FAULT_CLR,
  input  logic A_HI,
  input  logic A_LO,
  input  logic B_HI,
  input  logic B_LO,
  input  logic C_HI,
  input  logic C_LO,
  output logic A1,
  output logic AA1,
  output logic B1,
  output logic BB1,
  output logic C1,
  output logic CC1,
  output logic FAULT
);

  typedef enum logic [1:0] {OFF, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] DT  = CNT_W'(DT_CYCLES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [2:0]       hi_q;
  logic [2:0]       lo_q;
  logic [2:0]       req_h;
  logic [2:0]       req_l;
  logic [2:0]       ill;
  logic [2:0]       gh;
  logic [2:0]       gl;
  logic [2:0]       on_done;
  logic             any_ill;
  logic             fault;
  logic             forced;
  state_t           st  [3];
  logic [CNT_W-1:0] cnt [3];

  always_ff @(posedge CLK) begin
    if (RST) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= {C_HI, B_HI, A_HI};
      lo_q <= {C_LO, B_LO, A_LO};
    end
  end

  assign req_h   = hi_q & ~lo_q;
  assign req_l   = lo_q & ~hi_q;
  assign ill     = hi_q & lo_q;
  assign any_ill = |ill;
  // An illegal request drops the gates on the same edge that latches FAULT.
  assign forced  = ~EN | fault | any_ill;

`ifdef BLDC_DT_MIN_ON_EN
  localparam logic [CNT_W-1:0] MIN_ON = CNT_W'(MIN_ON_CYCLES);

  logic [CNT_W-1:0] ton [3];

  always_comb begin
    on_done = '0;
    for (int i = 0; i < 3; i++) begin
      on_done[i] = (ton[i] >= MIN_ON);
    end
  end

  // ton reads 1 on the first edge spent in HIGH/LOW.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (RST || st[i] == OFF) begin
        ton[i] <= ONE;
      end else if (!on_done[i]) begin
        ton[i] <= ton[i] + ONE;
      end
    end
  end
`else
  assign on_done = '1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 3; i++) begin
        st[i]  <= OFF;
        cnt[i] <= '0;
      end
      gh <= '0;
      gl <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        unique case (st[i])
          OFF: begin
            if (cnt[i] != DT) cnt[i] <= cnt[i] + ONE;
            if (!forced && cnt[i] == DT && req_h[i]) begin
              st[i] <= HIGH;
              gh[i] <= 1'b1;
            end else if (!forced && cnt[i] == DT && req_l[i]) begin
              st[i] <= LOW;
              gl[i] <= 1'b1;
            end
          end
          HIGH: begin
            if (forced || (!req_h[i] && on_done[i])) begin
              st[i]  <= OFF;
              cnt[i] <= ONE;
              gh[i]  <= 1'b0;
            end
          end
          LOW: begin
            if (forced || (!req_l[i] && on_done[i])) begin
              st[i]  <= OFF;
              cnt[i] <= ONE;
              gl[i]  <= 1'b0;
            end
          end
          default: begin
            st[i]  <= OFF;
            cnt[i] <= ONE;
            gh[i]  <= 1'b0;
            gl[i]  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fault <= 1'b0;
    end else if (any_ill) begin
      fault <= 1'b1;
    end else if (FAULT_CLR) begin
      fault <= 1'b0;
    end
  end

  assign A1    = gh[0];
  assign B1    = gh[1];
  assign C1    = gh[2];
  assign AA1   = gl[0];
  assign BB1   = gl[1];
  assign CC1   = gl[2];
  assign FAULT = fault;

endmodule

// File: tb/tb_bldc_deadtime_gate.sv
// Directed-vector bench for bldc_deadtime_gate at default parameters.
// Bit order in all 3-bit vectors is {C, B, A}.
module tb_bldc_deadtime_gate;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic [2:0] hi = '0;
  logic [2:0] lo = '0;
  logic a1, aa1, b1, bb1, c1, cc1, flt;

  int n_cmp = 0;
  int n_bad = 0;
  bit done = 1'b0;

  bldc_deadtime_gate dut (
    .CLK(clk), .RST(rst), .EN(en), .FAULT_CLR(clr),
    .A_HI(hi[0]), .A_LO(lo[0]),
    .B_HI(hi[1]), .B_LO(lo[1]),
    .C_HI(hi[2]), .C_LO(lo[2]),
    .A1(a1), .B1(b1), .C1(c1),
    .AA1(aa1), .BB1(bb1), .CC1(cc1),
    .FAULT(flt)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic       en;
    logic       clr;
    logic [2:0] hi;
    logic [2:0] lo;
    logic [2:0] eh;
    logic [2:0] el;
    logic       ef;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic e, input logic c,
                     input logic [2:0] h, input logic [2:0] l,
                     input logic [2:0] xh, input logic [2:0] xl,
                     input logic xf, input int n);
    vec_t v;
    v.en = e; v.clr = c; v.hi = h; v.lo = l;
    v.eh = xh; v.el = xl; v.ef = xf;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [2:0] xh,
                     input logic [2:0] xl, input logic xf);
    logic [6:0] got, exp;
    got = {flt, cc1, bb1, aa1, c1, b1, a1};
    exp = {xf, xl, xh};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {F,CC,BB,AA,C,B,A}=%b required %b", nm, got, exp);
    end
  endtask

  // Complementary gates of one phase must never overlap.
  always @(negedge clk) begin
    if (!done) begin
      n_cmp++;
      if (((a1 & aa1) | (b1 & bb1) | (c1 & cc1)) === 1'b1) begin
        n_bad++;
        $display("FAIL overlap: got hi=%b%b%b lo=%b%b%b required no overlap",
                 c1, b1, a1, cc1, bb1, aa1);
      end
    end
  end

  initial begin
    logic a_exp;

    // Power-on: A turns on 9 edges after reset releases.
    add(1, 0, 3'b001, 3'b000, 3'b000, 3'b000, 0, 8);
    add(1, 0, 3'b001, 3'b000, 3'b001, 3'b000, 0, 2);
    // A HI->LO reversal with full dead time.
    add(1, 0, 3'b000, 3'b001, 3'b001, 3'b000, 0, 1);
    add(1, 0, 3'b000, 3'b001, 3'b000, 3'b000, 0, 8);
    add(1, 0, 3'b000, 3'b001, 3'b000, 3'b001, 0, 1);
    // B high and C low start together, A stays low.
    add(1, 0, 3'b010, 3'b101, 3'b000, 3'b001, 0, 1);
    add(1, 0, 3'b010, 3'b101, 3'b010, 3'b101, 0, 1);
    // EN low for 3 cycles, gates return after the dead time.
    add(0, 0, 3'b010, 3'b101, 3'b000, 3'b000, 0, 3);
    add(1, 0, 3'b010, 3'b101, 3'b000, 3'b000, 0, 5);
    add(1, 0, 3'b010, 3'b101, 3'b010, 3'b101, 0, 1);
    // EN low past the dead time: gates wait for EN.
    add(0, 0, 3'b010, 3'b101, 3'b000, 3'b000, 0, 10);
    add(1, 0, 3'b010, 3'b101, 3'b010, 3'b101, 0, 1);
    // B shoot-through request for one cycle.
    add(1, 0, 3'b010, 3'b111, 3'b010, 3'b101, 0, 1);
    add(1, 0, 3'b010, 3'b101, 3'b000, 3'b000, 1, 9);
    // C illegal overlapping FAULT_CLR keeps the fault.
    add(1, 0, 3'b110, 3'b101, 3'b000, 3'b000, 1, 1);
    add(1, 1, 3'b110, 3'b101, 3'b000, 3'b000, 1, 1);
    add(1, 1, 3'b010, 3'b101, 3'b000, 3'b000, 1, 1);
    add(1, 1, 3'b010, 3'b101, 3'b000, 3'b000, 0, 1);
    add(1, 0, 3'b010, 3'b101, 3'b010, 3'b101, 0, 1);
    // A LO->HI reversal.
    add(1, 0, 3'b011, 3'b100, 3'b010, 3'b101, 0, 1);
    add(1, 0, 3'b011, 3'b100, 3'b010, 3'b100, 0, 8);
    add(1, 0, 3'b011, 3'b100, 3'b011, 3'b100, 0, 1);

    rst = 1'b1;
    tick();
    chk("reset", 3'b000, 3'b000, 1'b0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      en = tbl[i].en;
      clr = tbl[i].clr;
      hi = tbl[i].hi;
      lo = tbl[i].lo;
      tick();
      chk($sformatf("vec[%0d]", i), tbl[i].eh, tbl[i].el, tbl[i].ef);
    end
    clr = 1'b0;

    // Reset while A1 is on, then a full 9-edge restart.
    rst = 1'b1;
    tick();
    chk("mid_reset", 3'b000, 3'b000, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("restart_gap[%0d]", k), 3'b000, 3'b000, 1'b0);
    end
    tick();
    chk("restart_on", 3'b011, 3'b100, 1'b0);

    // Single-cycle A_HI pulse from a saturated OFF.
    hi = 3'b010;
    tick();
    chk("a_release", 3'b011, 3'b100, 1'b0);
    repeat (9) tick();
    chk("a_off_sat", 3'b010, 3'b100, 1'b0);
    hi = 3'b011;
    tick();
    chk("pulse_reg", 3'b010, 3'b100, 1'b0);
    hi = 3'b010;
    tick();
    chk("pulse_on", 3'b011, 3'b100, 1'b0);
    for (int k = 2; k <= 6; k++) begin
      tick();
`ifdef BLDC_DT_MIN_ON_EN
      a_exp = (k <= 4);
`else
      a_exp = 1'b0;
`endif
      chk($sformatf("pulse_len[%0d]", k), {2'b01, a_exp}, 3'b100, 1'b0);
    end

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
